proc_trace_recorder: RTL and testbench

- Hardware trace writer for the single-cycle processor. Each clock it samples the processor's observable outputs (PC_Value, Instruction, Jump, PC_Scr, Result) as one 98-bit record, in the same bit order as the processor test-vector format.
- Records are buffered in a FIFO and drained as 32-bit words over a valid/ready stream to a host or log memory.
- Sits beside CS3421_RRK_Processor and produces the vectors that the self-checking bench consumes.

---
 rtl/proc_trace_pkg.sv | 44 ++++
 rtl/proc_trace_recorder_if.sv | 15 +
 rtl/trace_fifo.sv | 55 +++++
 rtl/proc_trace_recorder.sv | 118 +++++++++++
 tb/tb_proc_trace_recorder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_trace_pkg.sv
// Shared constants, serializer state and record-to-word helpers for the
// processor trace recorder.
package proc_trace_pkg;

  localparam int RECORD_W      = 98;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_REC = 4;

  localparam logic [1:0] IDX_W0 = 2'd0;
  localparam logic [1:0] IDX_W1 = 2'd1;
  localparam logic [1:0] IDX_W2 = 2'd2;
  localparam logic [1:0] IDX_W3 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    W0,
    W1,
    W2,
    W3
  } ser_state_t;

  // Record is {PC_Value, Instruction, Jump, PC_Scr, Result}, MSB first.
  function automatic logic [WORD_W-1:0] rec_word(input logic [RECORD_W-1:0] rec,
                                                 input logic [1:0] idx);
    rec_word = '0;
    case (idx)
      IDX_W0: rec_word = rec[97:66];
      IDX_W1: rec_word = rec[65:34];
      IDX_W2: rec_word = {30'b0, rec[33:32]};
      IDX_W3: rec_word = rec[31:0];
    endcase
  endfunction

  function automatic logic [1:0] state_idx(input ser_state_t st);
    state_idx = IDX_W0;
    case (st)
      W1:      state_idx = IDX_W1;
      W2:      state_idx = IDX_W2;
      W3:      state_idx = IDX_W3;
      default: state_idx = IDX_W0;
    endcase
  endfunction

endpackage

// File: rtl/proc_trace_recorder_if.sv
// Word stream from the trace recorder to a host or log memory.
// A word transfers on a rising edge where out_valid and out_ready are both 1;
// once out_valid is raised, out_data/out_last hold until that transfer.
interface proc_trace_recorder_if;
  import proc_trace_pkg::*;

  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/trace_fifo.sv
// Record FIFO with combinational head read; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 98,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [WIDTH-1:0]           dout_next,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign dout      = mem[rd_ptr];
  assign dout_next = mem[rd_ptr + PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/proc_trace_recorder.sv
// Samples one processor record per enabled cycle, buffers it and streams it
// out as four 32-bit words with registered stream outputs.
module proc_trace_recorder
  import proc_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [31:0]                PC_Value,
  input  logic [31:0]                Instruction,
  input  logic                       Jump,
  input  logic                       PC_Scr,
  input  logic [31:0]                Result,
  proc_trace_recorder_if.master      stream,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count,
  output logic [$clog2(DEPTH+1)-1:0] record_count,
  output ser_state_t                 dbg_state
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [RECORD_W-1:0] rec_in;
  logic [RECORD_W-1:0] fifo_dout;
  logic [RECORD_W-1:0] fifo_dout_next;
  logic [RECORD_W-1:0] cur_rec;
  logic [RECORD_W-1:0] load_rec;
  logic [RECORD_W-1:0] src_rec;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                push;
  logic                drop;
  logic                load;
  ser_state_t          state;
  ser_state_t          state_nxt;
  logic [WORD_W-1:0]   data_q;
  logic                valid_q;
  logic                last_q;

  assign rec_in = {PC_Value, Instruction, Jump, PC_Scr, Result};
  assign pop    = (state == W3) && stream.out_ready;
  assign push   = enable && (!fifo_full || pop);
  assign drop   = enable && !push;

  trace_fifo #(
    .WIDTH (RECORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (rec_in),
    .dout      (fifo_dout),
    .dout_next (fifo_dout_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (record_count)
  );

  // On a W3->W0 turnaround the next record is either already behind the head
  // or is the one being pushed this very cycle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_rec  = fifo_dout;
    case (state)
      IDLE: if (!fifo_empty) begin
        state_nxt = W0;
        load      = 1'b1;
      end
      W0: if (stream.out_ready) state_nxt = W1;
      W1: if (stream.out_ready) state_nxt = W2;
      W2: if (stream.out_ready) state_nxt = W3;
      W3: if (stream.out_ready) begin
        if (record_count > CNT_W'(1) || push) begin
          state_nxt = W0;
          load      = 1'b1;
          load_rec  = (record_count > CNT_W'(1)) ? fifo_dout_next : rec_in;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    src_rec = load ? load_rec : cur_rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_rec    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state   <= state_nxt;
      valid_q <= (state_nxt != IDLE);
      last_q  <= (state_nxt == W3);
      data_q  <= (state_nxt == IDLE) ? '0 : rec_word(src_rec, state_idx(state_nxt));
      if (load) cur_rec <= load_rec;
      if (drop) overflow <= 1'b1;
      if (drop && drop_count != '1) drop_count <= drop_count + DROP_W'(1);
    end
  end

  assign stream.out_data  = data_q;
  assign stream.out_valid = valid_q;
  assign stream.out_last  = last_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_proc_trace_recorder.sv
// Bench for proc_trace_recorder: directed scenarios plus random traffic
// checked against a record/word queue model.
module tb_proc_trace_recorder;
  import proc_trace_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic [31:0] result = '0;
  logic        jump = 1'b0;
  logic        pc_scr = 1'b0;
  logic        overflow;
  logic [15:0] drop_count;
  logic [4:0]  record_count;
  ser_state_t  dbg_state;

  proc_trace_recorder_if bus ();

  proc_trace_recorder #(.DEPTH(DEPTH), .DROP_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .PC_Value     (pc),
    .Instruction  (instr),
    .Jump         (jump),
    .PC_Scr       (pc_scr),
    .Result       (result),
    .stream       (bus),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .record_count (record_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] hs_log[$];
  int          held = 0;
  int          prev_held = 0;
  logic        exp_ovf = 1'b0;
  int          exp_drop = 0;
  bit          mon_on = 1'b0;
  bit          pop_now;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Checks state after the last edge, then advances the model to the next edge.
  always @(negedge clk) begin
    if (mon_on) begin
      check("record_count", 64'(record_count), 64'(held));
      check("overflow", 64'(overflow), 64'(exp_ovf));
      check("drop_count", 64'(drop_count), 64'(exp_drop));
      check("out_valid", 64'(bus.out_valid), 64'(prev_held > 0 && held > 0));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("word_available", 64'(0), 64'(1));
        else begin
          check("out_data", 64'(bus.out_data), 64'(exp_q[0]));
          check("out_last", 64'(bus.out_last), 64'((exp_q.size() % WORDS_PER_REC) == 1));
        end
      end else begin
        check("out_last_idle", 64'(bus.out_last), 64'(0));
      end

      prev_held = held;
      if (reset) begin
        exp_q.delete();
        held = 0;
        exp_ovf = 1'b0;
        exp_drop = 0;
      end else begin
        pop_now = 1'b0;
        if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
          hs_log.push_back(bus.out_data);
          pop_now = ((exp_q.size() % WORDS_PER_REC) == 1);
          void'(exp_q.pop_front());
          if (pop_now) held--;
        end
        if (enable) begin
          if (held < DEPTH) begin
            exp_q.push_back(pc);
            exp_q.push_back(instr);
            exp_q.push_back({30'b0, jump, pc_scr});
            exp_q.push_back(result);
            held++;
          end else begin
            exp_ovf = 1'b1;
            if (exp_drop < 65535) exp_drop++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rec(input logic en, input logic [31:0] p, input logic [31:0] i,
                           input logic j, input logic s, input logic [31:0] r);
    enable = en;
    pc = p;
    instr = i;
    jump = j;
    pc_scr = s;
    result = r;
  endtask

  task automatic drive_random(input logic en);
    drive_rec(en, $urandom, $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    enable = 1'b0;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!bus.out_valid && k < budget) begin
      cycle();
      k++;
    end
    if (!bus.out_valid) check("wait_valid_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    bus.out_ready = 1'b1;
    cycle();
    mon_on = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (10) cycle();
    check("idle_valid", 64'(bus.out_valid), 64'(0));
    check("idle_count", 64'(record_count), 64'(0));
    check("idle_state", 64'(dbg_state), 64'(IDLE));

    // Single record, sink always ready
    hs_log.delete();
    drive_rec(1'b1, 32'h00000004, 32'h20080005, 1'b0, 1'b1, 32'h00000005);
    cycle();
    enable = 1'b0;
    repeat (8) cycle();
    check("single_words", 64'(hs_log.size()), 64'(4));
    if (hs_log.size() == 4) begin
      check("single_w0", 64'(hs_log[0]), 64'h00000004);
      check("single_w1", 64'(hs_log[1]), 64'h20080005);
      check("single_w2", 64'(hs_log[2]), 64'h00000001);
      check("single_w3", 64'(hs_log[3]), 64'h00000005);
    end
    check("single_idle", 64'(bus.out_valid), 64'(0));

    // Backpressure during W1
    hs_log.delete();
    bus.out_ready = 1'b0;
    drive_rec(1'b1, 32'h00000004, 32'h20080005, 1'b0, 1'b1, 32'h00000005);
    cycle();
    enable = 1'b0;
    wait_valid(10);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    repeat (5) begin
      cycle();
      check("bp_data", 64'(bus.out_data), 64'h20080005);
      check("bp_valid", 64'(bus.out_valid), 64'(1));
    end
    bus.out_ready = 1'b1;
    repeat (6) cycle();
    check("bp_words", 64'(hs_log.size()), 64'(4));
    if (hs_log.size() == 4) begin
      check("bp_w1", 64'(hs_log[1]), 64'h20080005);
      check("bp_w3", 64'(hs_log[3]), 64'h00000005);
    end

    // Overflow: 20 captures with the sink stalled
    do_reset(2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_random(1'b1);
      pc = 32'(i * 4);
      cycle();
    end
    enable = 1'b0;
    check("ovf_count", 64'(record_count), 64'(16));
    check("ovf_flag", 64'(overflow), 64'(1));
    check("ovf_drops", 64'(drop_count), 64'(4));
    hs_log.delete();
    bus.out_ready = 1'b1;
    repeat (70) cycle();
    check("ovf_drain_words", 64'(hs_log.size()), 64'(64));
    if (hs_log.size() == 64) begin
      for (int i = 0; i < 16; i++) check("ovf_drain_pc", 64'(hs_log[4*i]), 64'(i * 4));
    end

    // Full FIFO with simultaneous pop and capture
    do_reset(2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_random(1'b1);
      cycle();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      drive_random(1'b1);
      cycle();
      check("full_pop_count", 64'(record_count), 64'(16));
    end
    check("full_pop_drops", 64'(drop_count), 64'(18));
    enable = 1'b0;
    repeat (70) cycle();

    // Reset after the W1 handshake
    do_reset(2);
    bus.out_ready = 1'b1;
    drive_random(1'b1);
    cycle();
    enable = 1'b0;
    repeat (3) cycle();
    hs_log.delete();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_mid_valid", 64'(bus.out_valid), 64'(0));
    check("rst_mid_count", 64'(record_count), 64'(0));
    repeat (5) cycle();
    check("rst_mid_words", 64'(hs_log.size()), 64'(0));

    // Random traffic
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      drive_random(1'($urandom_range(0, 99) < 60));
      bus.out_ready = 1'($urandom_range(0, 99) < 70);
      reset = 1'($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0;
    enable = 1'b0;
    bus.out_ready = 1'b1;
    repeat (80) cycle();
    check("final_empty", 64'(record_count), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
